fifo_byte_rx: RTL and testbench
===============================

# fifo_byte_rx

Serial byte receiver that sits directly upstream of the byte FIFO. It recovers 8-bit frames from an asynchronous serial line and presents each byte on `DB[7:0]` with a one-cycle `wr` strobe, the exact write interface the FIFO consumes. It watches the FIFO's `overflow` flag, drops bytes while it is asserted, and counts those drops. It also detects framing errors and short glitches on the line.

## Interface
- `CLKS_PER_BIT`, default 16: `Clk` cycles per serial bit. Even, ≥ 8.
- `DROP_W`, default 8: width of the dropped-byte counter.

- `Clk`  in  1  single system clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, LSB first, 1 start, 8 data, 1 stop.
- `overflow`  in  1  FIFO full/overflow flag, level.
- `DB`  out  8  received byte, held stable until the next `wr`.
- `wr`  out  1  one-cycle write strobe to the FIFO.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `drop_cnt`  out  DROP_W  saturating count of bytes discarded due to `overflow`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. All logic below uses the synchronized value `rxs`.
- FSM states are IDLE, START, DATA, STOP, BREAK.
  - IDLE: falling edge of `rxs` → START, clearing the bit-timer.
  - START: when the timer reaches CLKS_PER_BIT/2−1, sample `rxs`.
    - Low → DATA, timer reset.
    - High → glitch; return to IDLE with no outputs.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into the shift register, LSB first. After the 8th sample → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - High and `overflow`=0 → load `DB`, pulse `wr`, go to IDLE.
    - High and `overflow`=1 → `DB` unchanged, no `wr`, `drop_cnt`+1 (saturates at all-ones), go to IDLE.
    - Low → pulse `frame_err`, no `wr`, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A line held low never produces further frames.
- `overflow` is sampled only in the stop-bit decision cycle.
- Bit-timer width is $clog2(CLKS_PER_BIT). The bit counter is 3 bits and wraps at 8.

## Timing
- Reset values: `DB`=0, `wr`=0, `frame_err`=0, `drop_cnt`=0, `busy`=0, FSM=IDLE, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately. No `wr` is issued. After release, the block waits for a fresh falling edge.
- Latency from the `rx` falling edge to the `wr` cycle: 2 (sync) + 1 (edge detect) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles. For the default this is 155.
- `wr`, `DB` update and `drop_cnt` update all occur on the same edge. `DB` is valid on every cycle `wr` is high.
- `wr` and `frame_err` are never high together. Each is at most one cycle per frame.
- Back-to-back frames with zero idle are accepted: a falling edge in the cycle after the STOP decision starts the next frame.

## Configuration
- `FIFO_BYTE_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP to sample an even-parity bit.
  - Adds output `parity_err` (1-cycle pulse, reset 0).
  - On a mismatch the byte is dropped (no `wr`) and `parity_err` pulses in the stop-decision cycle. `drop_cnt` is not incremented.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no parity bit, no `parity_err` port, and the frame is 10 bits.

## Structure
- Shared package/include holds the FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK) and the frame-format constants (data bits=8, stop bits=1).
- One sub-module, `rx_sync2`: the 2-flop synchronizer with asynchronous active-low reset to 1.
- Top level holds the FSM, bit-timer, shift register and drop counter.

## Test plan
- Send 0xA5 with `overflow`=0 at the default timing → `DB`=0xA5, a single `wr` pulse 155 cycles after the falling edge, `busy` low the next cycle.
- Send 0x3C then 0xC3 back-to-back with no idle → two `wr` pulses 160 cycles apart, `DB`=0x3C then 0xC3.
- Hold `overflow`=1 and send 0x55 three times → no `wr`, `DB` keeps its previous value, `drop_cnt`=3. Preset the counter to 255, then send one more → `drop_cnt` stays at 255.
- Send 0x81 with the stop bit forced low, holding `rx` low 40 cycles after the stop bit → `frame_err` pulses once, no `wr`, FSM stays in BREAK until `rx` rises, then 0x12 is received correctly.
- Apply a 5-cycle low glitch on idle `rx` → no `wr`, no `frame_err`, FSM back in IDLE by cycle 11.
- Assert `Rst` during DATA bit 4 of a frame → all outputs 0 asynchronously. After release, the tail of the aborted frame produces no `wr`, and the next full frame 0x7E is received.

Source files
------------

// File: rtl/fifo_byte_rx_pkg.sv
// Shared types and frame-format constants for the serial byte receiver.
// The optional parity bit is enabled by defining FIFO_BYTE_RX_PARITY_EN.
package fifo_byte_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for the serial line.
// Resets to 1 so an idle-high line shows no false edge after reset.
module rx_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/fifo_byte_rx.sv
// Serial byte receiver feeding the byte FIFO write port (DB/wr).
// Define FIFO_BYTE_RX_PARITY_EN to add an even-parity bit and parity_err.
module fifo_byte_rx
   import fifo_byte_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DROP_W       = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              rx,
   input  logic              overflow,
   output logic [7:0]        DB,
   output logic              wr,
   output logic              frame_err,
`ifdef FIFO_BYTE_RX_PARITY_EN
   output logic              parity_err,
`endif
   output logic [DROP_W-1:0] drop_cnt,
   output logic              busy
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_C = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_C = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_C = 3'(DATA_BITS - 1);

   logic rxs;

   rx_sync2 u_sync (
      .clk_i  (Clk),
      .rst_ni (Rst),
      .d_i    (rx),
      .q_o    (rxs)
   );

   state_t                state_q, state_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [2:0]            bit_q, bit_d;
   logic [DATA_BITS-1:0]  sh_q, sh_d;
   logic [7:0]            db_q, db_d;
   logic                  wr_q, wr_d;
   logic                  ferr_q, ferr_d;
   logic [DROP_W-1:0]     drop_q, drop_d;
   logic                  rxs_prev_q;
   logic                  par_ok;

`ifdef FIFO_BYTE_RX_PARITY_EN
   logic par_q, par_d;
   logic perr_q, perr_d;

   assign par_ok = ~(^sh_q ^ par_q);
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      db_d    = db_q;
      wr_d    = 1'b0;
      ferr_d  = 1'b0;
      drop_d  = drop_q;
`ifdef FIFO_BYTE_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            tmr_d = '0;
            if (rxs_prev_q && !rxs) state_d = ST_START;
         end
         ST_START: begin
            if (tmr_q == HALF_C) begin
               tmr_d   = '0;
               bit_d   = '0;
               state_d = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tmr_q == FULL_C) begin
               tmr_d = '0;
               sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == LAST_C) begin
`ifdef FIFO_BYTE_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef FIFO_BYTE_RX_PARITY_EN
         ST_PARITY: begin
            if (tmr_q == FULL_C) begin
               tmr_d   = '0;
               par_d   = rxs;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tmr_q == FULL_C) begin
               tmr_d = '0;
               if (!rxs) begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end else begin
                  state_d = ST_IDLE;
                  if (!par_ok) begin
`ifdef FIFO_BYTE_RX_PARITY_EN
                     perr_d = 1'b1;
`endif
                  end else if (overflow) begin
                     if (drop_q != '1) drop_d = drop_q + 1'b1;
                  end else begin
                     db_d = sh_q;
                     wr_d = 1'b1;
                  end
               end
            end
         end
         ST_BREAK: begin
            tmr_d = '0;
            if (rxs) state_d = ST_IDLE;
         end
         default: begin
            tmr_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         db_q       <= '0;
         wr_q       <= 1'b0;
         ferr_q     <= 1'b0;
         drop_q     <= '0;
         rxs_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         db_q       <= db_d;
         wr_q       <= wr_d;
         ferr_q     <= ferr_d;
         drop_q     <= drop_d;
         rxs_prev_q <= rxs;
      end
   end

`ifdef FIFO_BYTE_RX_PARITY_EN
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         par_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign parity_err = perr_q;
`endif

   assign DB        = db_q;
   assign wr        = wr_q;
   assign frame_err = ferr_q;
   assign drop_cnt  = drop_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_byte_rx.sv
// Scoreboard bench for fifo_byte_rx: stimulus pushes expected outcomes,
// a negedge monitor pops them whenever wr or frame_err fires.
module tb_fifo_byte_rx;

   localparam int CPB     = 16;
   localparam int DW      = 8;
   localparam int LAT     = 3 + CPB / 2 + 9 * CPB;
   localparam int DMAX    = (1 << DW) - 1;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          rx;
   logic          overflow;
   logic [7:0]    DB;
   logic          wr;
   logic          frame_err;
   logic [DW-1:0] drop_cnt;
   logic          busy;
`ifdef FIFO_BYTE_RX_PARITY_EN
   logic          parity_err;
`endif

   fifo_byte_rx #(.CLKS_PER_BIT(CPB), .DROP_W(DW)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .rx         (rx),
      .overflow   (overflow),
      .DB         (DB),
      .wr         (wr),
      .frame_err  (frame_err),
`ifdef FIFO_BYTE_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .drop_cnt   (drop_cnt),
      .busy       (busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit          ferr;
      logic [7:0]  data;
      int unsigned cyc;
   } exp_t;

   exp_t        exq[$];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          drop_m = 0;
   logic [7:0]  db_m = 8'h00;
   bit          busy_chk = 1'b0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: every output event must match the head of the scoreboard
   always @(negedge Clk) begin
      exp_t e;
      if (busy_chk) begin
         busy_chk = 1'b0;
         chk("busy_after_wr", {31'd0, busy}, 32'd0);
      end
      if (wr || frame_err) begin
         chk("wr_ferr_excl", {31'd0, wr & frame_err}, 32'd0);
         if (exq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: wr=%0b ferr=%0b DB=%0h cyc %0d",
                     wr, frame_err, DB, cyc);
         end else begin
            e = exq.pop_front();
            chk("out_kind", {31'd0, frame_err}, {31'd0, e.ferr});
            chk("out_cyc", cyc, e.cyc);
            if (wr) begin
               chk("DB", {24'd0, DB}, {24'd0, e.data});
               busy_chk = 1'b1;
            end
         end
      end
   end

   // Reference: outcome decided from stop level and overflow at send time
   task automatic send(input logic [7:0] b, input bit stop_ok);
      exp_t       e;
      logic [9:0] fr;
      fr     = {stop_ok, b, 1'b0};
      e.cyc  = cyc + LAT;
      e.data = b;
      e.ferr = 1'b0;
      if (!stop_ok) begin
         e.ferr = 1'b1;
         exq.push_back(e);
      end else if (overflow) begin
         drop_m = (drop_m == DMAX) ? DMAX : drop_m + 1;
      end else begin
         exq.push_back(e);
         db_m = b;
      end
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (CPB) @(negedge Clk);
      end
      rx = 1'b1;
   endtask

   initial begin
      int unsigned t0;
      logic [7:0]  b;
      bit          sok;
      Rst      = 1'b0;
      rx       = 1'b1;
      overflow = 1'b0;
      #1;
      chk("rst_DB", {24'd0, DB}, 32'd0);
      chk("rst_wr", {31'd0, wr}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      repeat (5) @(negedge Clk);

      send(8'hA5, 1'b1);
      repeat (4) @(negedge Clk);
      chk("DB_A5", {24'd0, DB}, 32'h0000_00A5);

      send(8'h3C, 1'b1);
      send(8'hC3, 1'b1);
      repeat (10) @(negedge Clk);
      chk("DB_C3", {24'd0, DB}, {24'd0, db_m});

      overflow = 1'b1;
      repeat (3) send(8'h55, 1'b1);
      chk("drop_3", {24'd0, drop_cnt}, 32'd3);
      chk("DB_hold", {24'd0, DB}, {24'd0, db_m});
      repeat (DMAX - 3) send(8'(($urandom) & 8'hFF), 1'b1);
      chk("drop_max", {24'd0, drop_cnt}, DMAX);
      send(8'h55, 1'b1);
      chk("drop_sat", {24'd0, drop_cnt}, 32'(drop_m));
      overflow = 1'b0;
      repeat (8) @(negedge Clk);

      send(8'h81, 1'b0);
      rx = 1'b0;
      repeat (40) @(negedge Clk);
      chk("break_busy", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (6) @(negedge Clk);
      chk("break_exit", {31'd0, busy}, 32'd0);
      send(8'h12, 1'b1);
      repeat (6) @(negedge Clk);

      t0 = cyc;
      rx = 1'b0;
      repeat (4) @(negedge Clk);
      chk("glitch_start", {31'd0, busy}, 32'd1);
      @(negedge Clk);
      rx = 1'b1;
      repeat (6) @(negedge Clk);
      chk("glitch_cyc", cyc - t0, 32'd11);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge Clk);

      // 0xE0: tail after bit 4 is all ones, so no edge once reset lifts
      rx = 1'b0;
      repeat (CPB * 5) @(negedge Clk);
      repeat (CPB / 2) @(negedge Clk);
      #1 Rst = 1'b0;
      #1;
      drop_m = 0;
      db_m   = 8'h00;
      chk("ar_DB", {24'd0, DB}, 32'd0);
      chk("ar_wr", {31'd0, wr}, 32'd0);
      chk("ar_ferr", {31'd0, frame_err}, 32'd0);
      chk("ar_drop", {24'd0, drop_cnt}, 32'd0);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      @(negedge Clk);
      repeat (CPB / 2 - 1) @(negedge Clk);
      rx = 1'b1;
      repeat (4) @(negedge Clk);
      Rst = 1'b1;
      repeat (CPB * 4 + 20) @(negedge Clk);
      chk("abort_idle", {31'd0, busy}, 32'd0);
      send(8'h7E, 1'b1);
      repeat (4) @(negedge Clk);
      chk("DB_7E", {24'd0, DB}, 32'h0000_007E);

      for (int n = 0; n < 40; n++) begin
         b        = 8'($urandom_range(255, 0));
         sok      = ($urandom_range(9, 0) != 0);
         overflow = ($urandom_range(3, 0) == 0);
         send(b, sok);
         repeat (sok ? $urandom_range(20, 0) : $urandom_range(20, 4))
            @(negedge Clk);
      end
      overflow = 1'b0;
      repeat (20) @(negedge Clk);
      chk("rand_drop", {24'd0, drop_cnt}, 32'(drop_m));
      chk("rand_DB", {24'd0, DB}, {24'd0, db_m});
      chk("sb_empty", exq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
